mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that shares the `mux_4_to_1` datapath among four requesters. It grants ownership to one requester at a time and drives the mux `sel` from a registered, glitch-free encoding of the current owner. It sits directly in front of the mux select input and is the only driver of `sel`.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before forced rotation. Used only when `MUX_ARB_HOLD_LIMIT_EN` is defined. Legal range 2..255.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req` input 4: request per requester; bit i maps to mux input i (a,b,c,d = 0,1,2,3).
- `gnt` output 4: one-hot grant, registered.
- `sel` output 2: mux select, registered; equals the binary index of the current or last owner.
- `busy` output 1: registered; high when `gnt` is non-zero.

## Operation
- State machine with two states.
  - IDLE: `gnt` is 0.
  - GRANT: exactly one `gnt` bit is high.
- Pointer `ptr[1:0]` marks the highest-priority index. Priority order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
- **IDLE:**
  - If `req` is non-zero, pick the first requesting index in priority order.
  - Next edge: enter GRANT, set `gnt` and `sel` to the winner, set `ptr` = winner+1 (mod 4), clear `cnt`.
- **GRANT, owner's `req` still high:**
  - Hold `gnt` and `sel`.
  - `cnt` increments and saturates at `MAX_HOLD-1`.
- **GRANT, owner's `req` low:**
  - If other requests are present, hand off directly to the next winner in priority order on the same edge. There is no bubble cycle; `ptr` and `cnt` update as in IDLE.
  - If no other request is present, go to IDLE. `gnt` becomes 0 and `sel` holds the last owner.
- Requesters keep `req` high until they have been granted and have finished using the mux. Dropping `req` is the release.
- If `req` changes while it is not granted, nothing happens and no state is kept for it.
- `sel` changes only on an edge where `gnt` changes to a new owner. `sel` is never X.

## Timing
- Reset values: `gnt`=0000, `sel`=00, `busy`=0, `ptr`=0, `cnt`=0, state IDLE.
- Reset is asynchronous. Asserting `rst_n` mid-grant drops `gnt` and `busy` immediately, without waiting for a clock edge.
- Grant latency is one cycle: a request sampled at edge k gives `gnt` visible after edge k.
- Release-to-handoff is one cycle: `gnt` moves on the first edge at which the owner's `req` is sampled low.
- Simultaneous requests: resolved by `ptr` only.
- After reset, with all four requesting, index 0 wins.
- Wrap-around: a winner of 3 sets `ptr` to 0.

## Configuration
- Macro: `MUX_ARB_HOLD_LIMIT_EN`.
- **Defined:**
  - When `cnt`==`MAX_HOLD-1` and any non-owner `req` is high, the next edge revokes the owner's grant and grants the next non-owner in priority order.
  - The revoked owner keeps `req` high and is re-served in normal rotation.
  - With no competitor, the grant persists and `cnt` stays saturated.
- **Undefined:** there is no `cnt` register and `MAX_HOLD` is ignored. A grant persists until the owner releases it.

## Structure
- Package `mux_arb_pkg` holds:
  - the state enum (IDLE, GRANT);
  - `NREQ`=4;
  - `SEL_W`=2.
- Sub-module `rr_pick4`: a combinational priority picker.
  - Inputs: `req[3:0]`, `ptr[1:0]`, `mask[3:0]`. The mask excludes the current owner on revocation.
  - Outputs: one-hot winner, binary index, `found`.
- The top level holds the FSM, `ptr`, `cnt` and the output registers.

## Test plan
- **Async reset:** in GRANT with `gnt`=0100, drop `rst_n` between edges -> `gnt`=0000, `busy`=0 and `sel`=00 immediately, without a clock edge.
- **Single request:** `req`=0010 for 3 cycles, then 0000 -> `gnt`=0010, `sel`=01 and `busy`=1 one cycle after the first sample; `gnt`=0000 one cycle after release, with `sel` held at 01.
- **Back-to-back from reset:** `req`=1111, each owner releases after 2 cycles of grant -> grant order 0,1,2,3 with no idle cycle between grants; `sel` sequence 00,01,10,11.
- **Fairness:** owner 0 releases then re-requests on the next cycle while `req[2]` is pending -> `gnt`=0100 before 0001 returns.
- **Hold limit** (macro defined, `MAX_HOLD`=4): `req[0]` held, `req[3]` asserted during grant 0 -> `gnt` switches to 1000 after exactly 4 cycles of 0001. With the macro undefined -> `gnt` stays 0001.
- **Hold limit, no competitor** (macro defined): `req`=0001 held for 20 cycles -> `gnt` stays 0001 and `sel` stays 00 throughout.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and widths for the mux4 round-robin arbiter
package mux_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Binary index to one-hot request vector
  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority picker over four requests
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [NREQ-1:0]  mask,
  output logic [NREQ-1:0]  win_onehot,
  output logic [SEL_W-1:0] win_idx,
  output logic             found
);

  logic [NREQ-1:0] cand;

  assign cand = req & ~mask;

  // Walk from ptr upward (mod 4); the first candidate seen wins
  always_comb begin
    logic [SEL_W-1:0] idx;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && cand[idx]) begin
        win_idx = idx;
        found   = 1'b1;
      end
    end
  end

  assign win_onehot = found ? idx_to_onehot(win_idx) : '0;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin owner of the mux_4_to_1 select; optional hold limit via MUX_ARB_HOLD_LIMIT_EN
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_TOP = 8'(MAX_HOLD - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  logic             owner_req;
  logic [NREQ-1:0]  pick_mask;
  logic [NREQ-1:0]  win_onehot;
  logic [SEL_W-1:0] win_idx;
  logic             win_found;
  logic             take;

  // Owner still holding the mux; while it is, it must never win the pick again
  always_comb begin
    owner_req = |(req & gnt_q);
    pick_mask = (state_q == ARB_GRANT && owner_req) ? gnt_q : '0;
  end

  rr_pick4 u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .mask       (pick_mask),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .found      (win_found)
  );

  // Next-state: grant, hand off without a bubble, revoke on hold limit, or go idle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    take    = 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (win_found) take = 1'b1;
      end
      ARB_GRANT: begin
        if (!owner_req) begin
          if (win_found) begin
            take = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
          end
        end else begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
          if (cnt_q == HOLD_TOP && win_found) begin
            take = 1'b1;
          end else if (cnt_q != HOLD_TOP) begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase

    if (take) begin
      state_d = ARB_GRANT;
      gnt_d   = win_onehot;
      sel_d   = win_idx;
      ptr_d   = win_idx + SEL_W'(1);
`ifdef MUX_ARB_HOLD_LIMIT_EN
      cnt_d   = '0;
`endif
    end

    busy_d = |gnt_d;
  end

  // State and output registers; reset clears grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MUX_ARB_HOLD_LIMIT_EN
  // Consecutive-grant counter, saturating at MAX_HOLD-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - randomized and directed bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  int n_vec;
  int n_err;

  // Reference: owner (-1 = none), priority pointer, last select, grant age
  int m_owner;
  int m_ptr;
  int m_sel;
  int m_hold;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int excl);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_sel   = 0;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int w;
    w = -1;
    if (m_owner >= 0 && r[m_owner]) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
      if (m_hold == MAX_HOLD - 1) w = pick(r, m_owner);
      if (w < 0 && m_hold < MAX_HOLD - 1) m_hold++;
`endif
    end else begin
      w = pick(r, -1);
      if (w < 0) m_owner = -1;
    end
    if (w >= 0) begin
      m_owner = w;
      m_sel   = w;
      m_ptr   = (w + 1) % 4;
      m_hold  = 0;
    end
  endtask

  function automatic logic [7:0] m_gnt();
    return (m_owner >= 0) ? 8'(1 << m_owner) : 8'd0;
  endfunction

  task automatic check_model(input string tag);
    check_val({tag, ".gnt"}, 8'(gnt), m_gnt());
    check_val({tag, ".sel"}, 8'(sel), 8'(m_sel));
    check_val({tag, ".busy"}, 8'(busy), (m_owner >= 0) ? 8'd1 : 8'd0);
  endtask

  // Apply one request vector across one rising edge, then compare
  task automatic step(input string tag, input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0] pend;
    logic [3:0] seq_gnt [9];
    int         used [4];
    int         seen;
    int         cnt_own;
    logic [3:0] r;

    n_vec = 0;
    n_err = 0;
    req   = 4'b0000;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_val("rst.gnt", 8'(gnt), 8'd0);
    check_val("rst.sel", 8'(sel), 8'd0);
    check_val("rst.busy", 8'(busy), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, then release: sel holds the last owner
    for (int i = 0; i < 3; i++) begin
      step("single", 4'b0010);
      check_val("single.gnt_c", 8'(gnt), 8'h02);
      check_val("single.sel_c", 8'(sel), 8'h01);
    end
    step("single_rel", 4'b0000);
    check_val("single_rel.gnt_c", 8'(gnt), 8'h00);
    check_val("single_rel.sel_c", 8'(sel), 8'h01);
    check_val("single_rel.busy_c", 8'(busy), 8'h00);

    // All four request from reset; each owner keeps the mux for two cycles
    do_reset();
    seq_gnt = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                4'b1000, 4'b1000, 4'b0000};
    pend = 4'b1111;
    for (int i = 0; i < 4; i++) used[i] = 0;
    for (int c = 0; c < 9; c++) begin
      step("b2b", pend);
      check_val("b2b.order", 8'(gnt), 8'(seq_gnt[c]));
      if (m_owner >= 0) begin
        used[m_owner]++;
        if (used[m_owner] == 2) pend[m_owner] = 1'b0;
      end
    end
    check_val("b2b.last_sel", 8'(sel), 8'h03);

    // Fairness: a pending requester is served before the previous owner returns
    do_reset();
    step("fair", 4'b0001);
    step("fair", 4'b0101);
    step("fair", 4'b0100);
    check_val("fair.to2", 8'(gnt), 8'h04);
    step("fair", 4'b0101);
    check_val("fair.hold2", 8'(gnt), 8'h04);
    step("fair", 4'b0001);
    check_val("fair.back0", 8'(gnt), 8'h01);
    step("fair", 4'b0000);

    // Async reset between edges while requester 2 owns the mux
    do_reset();
    step("areset_pre", 4'b0100);
    check_val("areset.pre_gnt", 8'(gnt), 8'h04);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("areset.gnt", 8'(gnt), 8'h00);
    check_val("areset.busy", 8'(busy), 8'h00);
    check_val("areset.sel", 8'(sel), 8'h00);
    model_reset();
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;

    // Lone requester holds indefinitely, with or without a hold limit
    for (int i = 0; i < 20; i++) begin
      step("nocomp", 4'b0001);
      check_val("nocomp.gnt_c", 8'(gnt), 8'h01);
      check_val("nocomp.sel_c", 8'(sel), 8'h00);
    end
    step("nocomp_rel", 4'b0000);

    // Competitor arrives during a long grant to requester 0
    do_reset();
    step("hold", 4'b0001);
    cnt_own = 1;
    seen    = 0;
    for (int i = 0; i < 11; i++) begin
      step("hold", 4'b1001);
      if (gnt == 4'b0001 && seen == 0) cnt_own++;
      else seen = 1;
    end
`ifdef MUX_ARB_HOLD_LIMIT_EN
    check_val("hold.cycles_of_0001", 8'(cnt_own), 8'(MAX_HOLD));
`else
    check_val("hold.cycles_of_0001", 8'(cnt_own), 8'd12);
`endif
    step("hold", 4'b1000);
    check_val("hold.rel_to3", 8'(gnt), 8'h08);
    step("hold", 4'b0000);

    // Random traffic against the reference, with occasional resets
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      else if (m_owner >= 0 && $urandom_range(0, 4) == 0) r[m_owner] = 1'b0;
      else r = r | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      step("rand", r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
